// File: rtl/mem_responder.sv
// Memory-side responder: answers read/write requests after fixed latencies
// from a local line buffer, standing in for host memory.
module mem_responder #(
  parameter int DEPTH        = 64,
  parameter int RD_LAT       = 4,
  parameter int WR_LAT       = 2,
  parameter int ADDR_VLD_DLY = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              address,
  input  logic                     read_request_valid,
  input  logic                     write_request_valid,
  input  logic [511:0]             write_data,
  output logic                     buffer_addr_valid,
  output logic                     data_valid,
  output logic [511:0]             read_data,
  output logic                     write_done,
  input  logic                     preload_we,
  input  logic [$clog2(DEPTH)-1:0] preload_idx,
  input  logic [511:0]             preload_data,
  output logic                     proto_err
);

  localparam int IDXW   = $clog2(DEPTH);
  localparam int LATMAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNTW   = (LATMAX > 1) ? $clog2(LATMAX) : 1;
  localparam int DLYW   = (ADDR_VLD_DLY > 1) ? $clog2(ADDR_VLD_DLY) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t           r_state;
  logic [CNTW-1:0]  r_cnt;
  logic [IDXW-1:0]  r_idx;
  logic             r_oob;
  logic [511:0]     r_wdata;
  logic [DLYW-1:0]  r_dlyCnt;
  logic             r_addrValid;
  logic             r_dataValid;
  logic             r_writeDone;
  logic [511:0]     r_readData;
  logic             r_protoErr;
  logic [511:0]     r_buf [DEPTH];

  logic             w_anyReq;
  logic             w_oob;
  logic [IDXW-1:0]  w_idx;
  logic             w_commit;

  assign w_anyReq = read_request_valid | write_request_valid;
  assign w_oob    = (address >= 32'(DEPTH));
  assign w_idx    = address[IDXW-1:0];
  assign w_commit = (r_state == WR_WAIT) && (r_cnt == '0) && !r_oob;

  assign buffer_addr_valid = r_addrValid;
  assign data_valid        = r_dataValid;
  assign write_done        = r_writeDone;
  assign read_data         = r_readData;
  assign proto_err         = r_protoErr;

  // Ready delay counter; it freezes once the buffer is declared valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dlyCnt    <= '0;
      r_addrValid <= 1'b0;
    end else if (!r_addrValid) begin
      if (r_dlyCnt == DLYW'(ADDR_VLD_DLY - 1))
        r_addrValid <= 1'b1;
      else
        r_dlyCnt <= r_dlyCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_oob       <= 1'b0;
      r_wdata     <= '0;
      r_dataValid <= 1'b0;
      r_writeDone <= 1'b0;
      r_readData  <= '0;
      r_protoErr  <= 1'b0;
    end else begin
      r_dataValid <= 1'b0;
      r_writeDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq && r_addrValid) begin
            r_idx <= w_idx;
            r_oob <= w_oob;
            if (w_oob || (read_request_valid && write_request_valid))
              r_protoErr <= 1'b1;
            if (read_request_valid) begin
              r_state <= RD_WAIT;
              r_cnt   <= CNTW'(RD_LAT - 1);
            end else begin
              r_state <= WR_WAIT;
              r_cnt   <= CNTW'(WR_LAT - 1);
              r_wdata <= write_data;
            end
          end
        end
        RD_WAIT: begin
          if (r_cnt == '0) begin
            r_dataValid <= 1'b1;
            r_readData  <= r_oob ? '0 : r_buf[r_idx];
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WR_WAIT: begin
          if (r_cnt == '0) begin
            r_writeDone <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_anyReq && (!r_addrValid || r_state != IDLE))
        r_protoErr <= 1'b1;
    end
  end

  // Buffer survives reset; the commit is written last so it wins a same-line preload.
  always_ff @(posedge clk) begin
    if (preload_we)
      r_buf[preload_idx] <= preload_data;
    if (w_commit)
      r_buf[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_mem_responder;

  localparam int DEPTH        = 64;
  localparam int RD_LAT       = 4;
  localparam int WR_LAT       = 2;
  localparam int ADDR_VLD_DLY = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address;
  logic         read_request_valid;
  logic         write_request_valid;
  logic [511:0] write_data;
  logic         buffer_addr_valid;
  logic         data_valid;
  logic [511:0] read_data;
  logic         write_done;
  logic         preload_we;
  logic [5:0]   preload_idx;
  logic [511:0] preload_data;
  logic         proto_err;

  int total = 0;
  int bad   = 0;
  bit checkEn = 0;

  mem_responder #(
    .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .ADDR_VLD_DLY(ADDR_VLD_DLY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .read_request_valid(read_request_valid),
    .write_request_valid(write_request_valid),
    .write_data(write_data),
    .buffer_addr_valid(buffer_addr_valid),
    .data_valid(data_valid),
    .read_data(read_data),
    .write_done(write_done),
    .preload_we(preload_we),
    .preload_idx(preload_idx),
    .preload_data(preload_data),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Transaction-level model: one outstanding request with a due edge number.
  logic [511:0] mMem [DEPTH];
  int           mEdges;
  int           mCycle;
  bit           mValid;
  bit           mBusy;
  bit           mIsRead;
  int           mDue;
  int           mIdx;
  bit           mOob;
  logic [511:0] mWdata;
  bit           mDv;
  bit           mWd;
  bit           mErr;
  logic [511:0] mRd;
  bit           busyAtEdge;
  bit           doCommit;
  int           cIdx;
  logic [511:0] cData;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mEdges = 0; mCycle = 0; mValid = 0; mBusy = 0;
      mDv = 0; mWd = 0; mErr = 0; mRd = '0;
    end else begin
      mCycle++;
      busyAtEdge = mBusy;
      mDv = 0; mWd = 0; doCommit = 0;
      if (mBusy && mDue == mCycle) begin
        if (mIsRead) begin
          mDv = 1;
          mRd = mOob ? '0 : mMem[mIdx];
        end else begin
          mWd = 1;
          if (!mOob) begin doCommit = 1; cIdx = mIdx; cData = mWdata; end
        end
        mBusy = 0;
      end
      if (read_request_valid || write_request_valid) begin
        if (!mValid || busyAtEdge) mErr = 1;
        else begin
          mBusy   = 1;
          mIsRead = read_request_valid;
          mDue    = mCycle + (read_request_valid ? RD_LAT : WR_LAT);
          mOob    = address >= DEPTH;
          mIdx    = int'(address % DEPTH);
          mWdata  = write_data;
          if (mOob || (read_request_valid && write_request_valid)) mErr = 1;
        end
      end
      if (preload_we) mMem[preload_idx] = preload_data;
      if (doCommit) mMem[cIdx] = cData;
      mEdges++;
      if (mEdges >= ADDR_VLD_DLY) mValid = 1;
    end
  end

  task automatic checkOutput(string name, logic [511:0] got, logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmp_data_valid", 512'(data_valid), 512'(mDv));
      checkOutput("cmp_write_done", 512'(write_done), 512'(mWd));
      checkOutput("cmp_read_data", read_data, mRd);
      checkOutput("cmp_addr_valid", 512'(buffer_addr_valid), 512'(mValid));
      checkOutput("cmp_proto_err", 512'(proto_err), 512'(mErr));
    end
  end

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(bit rd, bit wr, logic [31:0] addr, logic [511:0] wdata,
                               bit pwe, logic [5:0] pidx, logic [511:0] pdata);
    read_request_valid  = rd;
    write_request_valid = wr;
    address             = addr;
    write_data          = wdata;
    preload_we          = pwe;
    preload_idx         = pidx;
    preload_data        = pdata;
    cycle();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, '0, 0, 0, '0);
  endtask

  logic [511:0] patA5;
  logic [511:0] patCafe;

  initial begin
    patA5   = {64{8'hA5}};
    patCafe = {16{32'hCAFE0003}};
    rst = 1;
    read_request_valid = 0; write_request_valid = 0; address = 0; write_data = '0;
    preload_we = 0; preload_idx = 0; preload_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    checkEn = 1;

    // Reset release: ready stays low for eight cycles; buffer filled meanwhile.
    checkOutput("t1_bav_k0", 512'(buffer_addr_valid), 512'(0));
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 0, '0, 1, 6'(i), (i == 3) ? patCafe : rand512());
      if (i < 9) checkOutput("t1_bav", 512'(buffer_addr_valid), 512'((i + 1) >= 8));
    end
    checkOutput("t1_dv", 512'(data_valid), 512'(0));
    checkOutput("t1_err", 512'(proto_err), 512'(0));

    // Preload then read: response exactly RD_LAT edges after the sample.
    applyStimulus(0, 0, 0, '0, 1, 6'd5, patA5);
    applyStimulus(1, 0, 5, '0, 0, 0, '0);
    idle(); idle(); idle();
    checkOutput("t2_dv_early", 512'(data_valid), 512'(0));
    idle();
    checkOutput("t2_dv", 512'(data_valid), 512'(1));
    checkOutput("t2_rd", read_data, patA5);
    idle();
    checkOutput("t2_dv_pulse", 512'(data_valid), 512'(0));
    checkOutput("t2_rd_hold", read_data, patA5);

    // Write then read back.
    applyStimulus(0, 1, 7, 512'h1234, 0, 0, '0);
    idle();
    checkOutput("t3_wd_early", 512'(write_done), 512'(0));
    idle();
    checkOutput("t3_wd", 512'(write_done), 512'(1));
    applyStimulus(1, 0, 7, '0, 0, 0, '0);
    idle(); idle(); idle(); idle();
    checkOutput("t3_dv", 512'(data_valid), 512'(1));
    checkOutput("t3_rd", read_data, 512'h1234);
    checkOutput("t3_err", 512'(proto_err), 512'(0));

    // Simultaneous read and write: read wins, write dropped, error raised.
    applyStimulus(1, 1, 3, 512'hDEAD, 0, 0, '0);
    checkOutput("t4_err", 512'(proto_err), 512'(1));
    idle(); idle(); idle();
    checkOutput("t4_wd", 512'(write_done), 512'(0));
    idle();
    checkOutput("t4_dv", 512'(data_valid), 512'(1));
    checkOutput("t4_rd", read_data, patCafe);
    idle();

    // Reset in the middle of a read: response abandoned, buffer retained.
    applyStimulus(1, 0, 5, '0, 0, 0, '0);
    idle(); idle();
    rst = 1;
    #1;
    checkOutput("t6_err_rst", 512'(proto_err), 512'(0));
    checkOutput("t6_rd_rst", read_data, 512'(0));
    idle(); idle();
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      checkOutput("t6_no_dv", 512'(data_valid), 512'(0));
    end
    applyStimulus(1, 0, 5, '0, 0, 0, '0);
    idle(); idle(); idle(); idle();
    checkOutput("t6_dv", 512'(data_valid), 512'(1));
    checkOutput("t6_rd", read_data, patA5);
    idle();

    // Out-of-range read: zero data at normal latency, error raised.
    applyStimulus(1, 0, 64, '0, 0, 0, '0);
    idle(); idle(); idle(); idle();
    checkOutput("t5_dv", 512'(data_valid), 512'(1));
    checkOutput("t5_rd", read_data, 512'(0));
    checkOutput("t5_err", 512'(proto_err), 512'(1));
    idle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      int r;
      if (n % 1000 == 500) begin
        idle();
        rst = 1;
        idle();
        rst = 0;
        for (int k = 0; k < ADDR_VLD_DLY; k++) idle();
      end
      r = $urandom_range(0, 99);
      applyStimulus(r < 20, (r >= 15) && (r < 35), $urandom_range(0, 71), rand512(),
                    $urandom_range(0, 9) == 0, 6'($urandom_range(0, 63)), rand512());
    end
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
